// File: rtl/sd_transfer_sequencer_pkg.sv
// Shared definitions for the SD transfer sequencer: FSM states and SD command indices.
package sd_defines;

  localparam int unsigned CMD_INDEX_W = 6;

  localparam logic [CMD_INDEX_W-1:0] CMD12 = 6'd12;
  localparam logic [CMD_INDEX_W-1:0] CMD17 = 6'd17;
  localparam logic [CMD_INDEX_W-1:0] CMD18 = 6'd18;
  localparam logic [CMD_INDEX_W-1:0] CMD24 = 6'd24;
  localparam logic [CMD_INDEX_W-1:0] CMD25 = 6'd25;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SEND_CMD,
    S_WAIT_CMD,
    S_START_DAT,
    S_WAIT_DAT,
    S_SEND_STOP,
    S_WAIT_STOP,
    S_DONE,
    S_FAIL
  } seq_state_t;

  function automatic logic [CMD_INDEX_W-1:0] xfer_cmd_index(input logic write_read,
                                                            input logic multiple);
    if (write_read) return multiple ? CMD25 : CMD24;
    return multiple ? CMD18 : CMD17;
  endfunction

endpackage

// File: rtl/sd_transfer_sequencer_timeout.sv
// Per-wait-state cycle counter; expired is asserted once TIMEOUT_CYCLES cycles have elapsed.
module sd_seq_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/sd_transfer_sequencer.sv
// Sequences a full SD block transfer: data command, per-block DAT starts, optional CMD12,
// with a timeout on every wait.
module sd_transfer_sequencer
  import sd_defines::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   write_read,
  input  logic [3:0]             block_count,
  input  logic [31:0]            address,
  output logic                   cmd_new,
  output logic [CMD_INDEX_W-1:0] cmd_index,
  output logic [31:0]            cmd_arg,
  input  logic                   cmd_done,
  input  logic                   cmd_error,
  output logic                   dat_new,
  output logic                   dat_write_read,
  output logic                   dat_multiple,
  output logic [3:0]             dat_blocks,
  input  logic                   dat_complete,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [3:0]             blocks_done
);

  seq_state_t state, state_next;
  logic       fail_flag, fail_next;
  logic       in_wait;
  logic       timeout_expired;

  assign in_wait = state inside {S_WAIT_CMD, S_WAIT_DAT, S_WAIT_STOP};

  // Every WAIT_* state is entered from a one-cycle SEND/START state, so holding the
  // counter clear outside the waits gives a fresh count on each entry.
  sd_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (timeout_expired)
  );

  always_comb begin
    state_next = state;
    fail_next  = fail_flag;
    case (state)
      S_IDLE: begin
        fail_next = 1'b0;
        if (start) state_next = (block_count == 4'd0) ? S_FAIL : S_SEND_CMD;
      end
      S_SEND_CMD:  state_next = S_WAIT_CMD;
      S_WAIT_CMD: begin
        if (cmd_done)             state_next = cmd_error ? S_FAIL : S_START_DAT;
        else if (timeout_expired) state_next = S_FAIL;
      end
      S_START_DAT: state_next = S_WAIT_DAT;
      S_WAIT_DAT: begin
        if (dat_complete) begin
          if (({1'b0, blocks_done} + 5'd1) < {1'b0, dat_blocks}) state_next = S_START_DAT;
          else if (dat_multiple)                                 state_next = S_SEND_STOP;
          else                                                   state_next = S_DONE;
        end else if (timeout_expired) begin
          // A stalled multi-block transfer still gets its CMD12; the failure is reported after it.
          if (dat_multiple) begin
            state_next = S_SEND_STOP;
            fail_next  = 1'b1;
          end else begin
            state_next = S_FAIL;
          end
        end
      end
      S_SEND_STOP: state_next = S_WAIT_STOP;
      S_WAIT_STOP: begin
        if (cmd_done)             state_next = (cmd_error || fail_flag) ? S_FAIL : S_DONE;
        else if (timeout_expired) state_next = S_FAIL;
      end
      S_DONE:  state_next = S_IDLE;
      S_FAIL:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= S_IDLE;
      fail_flag      <= 1'b0;
      cmd_new        <= 1'b0;
      cmd_index      <= '0;
      cmd_arg        <= '0;
      dat_new        <= 1'b0;
      dat_write_read <= 1'b0;
      dat_multiple   <= 1'b0;
      dat_blocks     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      blocks_done    <= '0;
    end else begin
      state     <= state_next;
      fail_flag <= fail_next;

      if (state == S_IDLE && start) begin
        dat_write_read <= write_read;
        dat_multiple   <= (block_count > 4'd1);
        dat_blocks     <= block_count;
        if (block_count != 4'd0) blocks_done <= '0;
      end else if (state == S_WAIT_DAT && dat_complete && blocks_done < dat_blocks) begin
        blocks_done <= blocks_done + 4'd1;
      end

      // Outputs decoded from the next state so they line up with the state they describe.
      cmd_new <= (state_next == S_SEND_CMD) || (state_next == S_SEND_STOP);
      if (state_next == S_SEND_CMD) begin
        cmd_index <= xfer_cmd_index(write_read, block_count > 4'd1);
        cmd_arg   <= address;
      end else if (state_next == S_SEND_STOP) begin
        cmd_index <= CMD12;
        cmd_arg   <= '0;
      end else begin
        cmd_index <= '0;
        cmd_arg   <= '0;
      end
      dat_new <= (state_next == S_START_DAT);
      busy    <= (state_next != S_IDLE);
      done    <= (state_next == S_DONE);
      error   <= (state_next == S_FAIL);
    end
  end

endmodule

// File: tb/tb_sd_transfer_sequencer.sv
// Directed bench for sd_transfer_sequencer: a table of whole transfers plus hand-timed sequences.
module tb_sd_transfer_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        write_read = 1'b0;
  logic [3:0]  block_count = '0;
  logic [31:0] address = '0;
  logic        cmd_done = 1'b0;
  logic        cmd_error = 1'b0;
  logic        dat_complete = 1'b0;

  logic        cmd_new, dat_new, dat_write_read, dat_multiple, busy, done, error;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [3:0]  dat_blocks, blocks_done;

  logic        cmd_new2, dat_new2, dat_write_read2, dat_multiple2, busy2, done2, error2;
  logic [5:0]  cmd_index2;
  logic [31:0] cmd_arg2;
  logic [3:0]  dat_blocks2, blocks_done2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sd_transfer_sequencer #(.TIMEOUT_CYCLES(1024)) dut (
    .clock(clock), .reset(reset), .start(start), .write_read(write_read),
    .block_count(block_count), .address(address), .cmd_new(cmd_new),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_done(cmd_done),
    .cmd_error(cmd_error), .dat_new(dat_new), .dat_write_read(dat_write_read),
    .dat_multiple(dat_multiple), .dat_blocks(dat_blocks), .dat_complete(dat_complete),
    .busy(busy), .done(done), .error(error), .blocks_done(blocks_done)
  );

  sd_transfer_sequencer #(.TIMEOUT_CYCLES(16)) dut_to (
    .clock(clock), .reset(reset), .start(start2), .write_read(write_read),
    .block_count(block_count), .address(address), .cmd_new(cmd_new2),
    .cmd_index(cmd_index2), .cmd_arg(cmd_arg2), .cmd_done(cmd_done),
    .cmd_error(cmd_error), .dat_new(dat_new2), .dat_write_read(dat_write_read2),
    .dat_multiple(dat_multiple2), .dat_blocks(dat_blocks2), .dat_complete(dat_complete),
    .busy(busy2), .done(done2), .error(error2), .blocks_done(blocks_done2)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  bc;
    logic [31:0] addr;
    logic        cerr;
    logic [5:0]  idx;
    int          dats;
    int          stops;
    int          dones;
    int          errs;
    logic        chk_bd;
    logic [3:0]  bd;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  dat_cnt = 0, stop_cnt = 0, done_cnt = 0, err_cnt = 0;
    int  cmd_cd = -1, dat_cd = -1;
    bit  first_cmd = 1'b1, pend_first = 1'b0, finished = 1'b0;
    write_read  = v.wr;
    block_count = v.bc;
    address     = v.addr;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("first_cmd_new", cmd_new, v.bc != 4'd0);
    if (v.bc != 4'd0) begin
      check("first_cmd_index", cmd_index, v.idx);
      check("first_cmd_arg", cmd_arg, v.addr);
      check("blocks_done_cleared", blocks_done, 4'd0);
      check("dat_blocks", dat_blocks, v.bc);
      check("dat_write_read", dat_write_read, v.wr);
      check("dat_multiple", dat_multiple, v.bc > 4'd1);
    end
    for (int c = 0; c < 1000 && !finished; c++) begin
      if (done)  done_cnt++;
      if (error) err_cnt++;
      if (done || error) begin
        finished = 1'b1;
      end else begin
        if (dat_new) dat_cnt++;
        if (cmd_new && !first_cmd) begin
          stop_cnt++;
          check("stop_index", cmd_index, 6'd12);
          check("stop_arg", cmd_arg, 32'd0);
        end
        cmd_done = 1'b0; cmd_error = 1'b0; dat_complete = 1'b0;
        if (cmd_cd == 0) begin
          cmd_done  = 1'b1;
          cmd_error = pend_first && v.cerr;
          cmd_cd    = -1;
        end else if (cmd_cd > 0) cmd_cd--;
        if (dat_cd == 0) begin
          dat_complete = 1'b1;
          dat_cd       = -1;
        end else if (dat_cd > 0) dat_cd--;
        if (cmd_new) begin
          cmd_cd     = 4;
          pend_first = first_cmd;
          first_cmd  = 1'b0;
        end
        if (dat_new) dat_cd = 19;
        step();
      end
    end
    cmd_done = 1'b0; cmd_error = 1'b0; dat_complete = 1'b0;
    check("vec_finished", finished, 1'b1);
    check("dat_new_count", dat_cnt, v.dats);
    check("stop_count", stop_cnt, v.stops);
    check("done_count", done_cnt, v.dones);
    check("error_count", err_cnt, v.errs);
    if (v.chk_bd) check("blocks_done_final", blocks_done, v.bd);
    step();
    check("busy_low_after_end", busy, 1'b0);
    check("done_pulse_ended", done, 1'b0);
    check("error_pulse_ended", error, 1'b0);
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b0, 4'd1,  32'h0000_0100, 1'b0, 6'd17, 1,  0, 1, 0, 1'b1, 4'd1};
    vecs[1] = '{1'b1, 4'd3,  32'h0000_2000, 1'b0, 6'd25, 3,  1, 1, 0, 1'b1, 4'd3};
    vecs[2] = '{1'b0, 4'd2,  32'h0000_0040, 1'b1, 6'd18, 0,  0, 0, 1, 1'b1, 4'd0};
    vecs[3] = '{1'b1, 4'd1,  32'hDEAD_BEEF, 1'b0, 6'd24, 1,  0, 1, 0, 1'b1, 4'd1};
    vecs[4] = '{1'b0, 4'd15, 32'h0000_0007, 1'b0, 6'd18, 15, 1, 1, 0, 1'b1, 4'd15};
    vecs[5] = '{1'b1, 4'd0,  32'h0000_0099, 1'b0, 6'd0,  0,  0, 0, 1, 1'b0, 4'd0};

    reset = 1'b0;
    step(); step();
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_new", cmd_new, 1'b0);
    check("rst_cmd_index", cmd_index, 6'd0);
    check("rst_cmd_arg", cmd_arg, 32'd0);
    check("rst_dat_blocks", dat_blocks, 4'd0);
    check("rst_blocks_done", blocks_done, 4'd0);
    reset = 1'b1;
    step();

    // Cycle-exact two-block read with an ignored second start while busy
    write_read = 1'b0; block_count = 4'd2; address = 32'h0000_1234;
    start = 1'b1; step(); start = 1'b0;
    check("seq_cmd_new", cmd_new, 1'b1);
    check("seq_cmd_index", cmd_index, 6'd18);
    check("seq_cmd_arg", cmd_arg, 32'h1234);
    check("seq_busy", busy, 1'b1);
    step();
    check("seq_cmd_new_pulse", cmd_new, 1'b0);
    cmd_done = 1'b1; step(); cmd_done = 1'b0;
    check("seq_dat_new1", dat_new, 1'b1);
    step();
    check("seq_dat_new_pulse", dat_new, 1'b0);
    start = 1'b1; write_read = 1'b1; block_count = 4'd5; address = 32'hFFFF;
    step(); start = 1'b0;
    check("busy_start_blocks", dat_blocks, 4'd2);
    check("busy_start_dir", dat_write_read, 1'b0);
    check("busy_start_no_cmd", cmd_new, 1'b0);
    dat_complete = 1'b1; step(); dat_complete = 1'b0;
    check("seq_dat_new2", dat_new, 1'b1);
    check("seq_blocks1", blocks_done, 4'd1);
    step();
    dat_complete = 1'b1; step(); dat_complete = 1'b0;
    check("seq_stop_new", cmd_new, 1'b1);
    check("seq_stop_index", cmd_index, 6'd12);
    check("seq_stop_arg", cmd_arg, 32'd0);
    check("seq_blocks2", blocks_done, 4'd2);
    step();
    cmd_done = 1'b1; step(); cmd_done = 1'b0;
    check("seq_done", done, 1'b1);
    check("seq_no_error", error, 1'b0);
    check("seq_busy_at_done", busy, 1'b1);
    step();
    check("seq_done_pulse", done, 1'b0);
    check("seq_busy_low", busy, 1'b0);
    write_read = 1'b1; block_count = 4'd2; address = 32'h55;
    start = 1'b1; step(); start = 1'b0;
    check("restart_cmd_new", cmd_new, 1'b1);
    check("restart_cmd_index", cmd_index, 6'd25);

    // Reset while in WAIT_DAT
    step();
    cmd_done = 1'b1; step(); cmd_done = 1'b0;
    step();
    dat_complete = 1'b1; step(); dat_complete = 1'b0;
    step();
    reset = 1'b0; step();
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dat_new", dat_new, 1'b0);
    check("mid_rst_blocks_done", blocks_done, 4'd0);
    check("mid_rst_dat_blocks", dat_blocks, 4'd0);
    check("mid_rst_multiple", dat_multiple, 1'b0);
    check("mid_rst_dir", dat_write_read, 1'b0);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cmd_new || busy) n++;
    end
    check("mid_rst_no_cmd12", n, 0);

    // WAIT_DAT timeout on the short-timeout instance
    write_read = 1'b0; block_count = 4'd2; address = 32'h77;
    start2 = 1'b1; step(); start2 = 1'b0;
    check("to_cmd_new", cmd_new2, 1'b1);
    step();
    cmd_done = 1'b1; step(); cmd_done = 1'b0;
    check("to_dat_new", dat_new2, 1'b1);
    step();
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      step();
      if (cmd_new2) n = i;
    end
    check("to_stop_latency", n, 16);
    check("to_stop_index", cmd_index2, 6'd12);
    check("to_stop_arg", cmd_arg2, 32'd0);
    step();
    cmd_done = 1'b1; step(); cmd_done = 1'b0;
    check("to_error", error2, 1'b1);
    check("to_not_done", done2, 1'b0);
    step();
    check("to_busy_low", busy2, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
